hazard_scoreboard: RTL and testbench

Parametrised hazard and forwarding controller for the pipelined core. It tracks every in-flight register write from Execute through Writeback in an internal shift pipeline. It drives forward-select codes for both Execute operands, and stall/flush controls for Fetch, Decode and Execute. It generalises the fixed 5-stage M/W match logic to any register count, any pipeline depth and per-instruction result latency (ALU, load, multi-cycle producers).

---
 rtl/hazard_pkg.sv | 14 +
 rtl/hazard_entry.sv | 49 ++++
 rtl/hazard_scoreboard.sv | 110 +++++++++++
 tb/tb_hazard_scoreboard.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared types for the hazard scoreboard: tracked-entry layout and forward codes.
// Entry fields are sized for the widest supported build; narrower instances zero-extend.
package hazard_pkg;
   localparam int AW_MAX = 8;
   localparam int LW_DEF = 2;
   localparam int LW_MAX = 4;
   localparam int FWD_RF = 0;

   typedef struct packed {
      logic              valid;
      logic [AW_MAX-1:0] wa;
      logic [LW_MAX-1:0] lat;
   } entry_t;
endpackage

// File: rtl/hazard_entry.sv
// One tracked pipeline position: shift register slot plus its forward, load-use and PC comparators.
module hazard_entry
   import hazard_pkg::*;
#(
   parameter int POS     = 0,
   parameter int PC_ADDR = 15
) (
   input  logic              clk,
   input  logic              reset,
   input  entry_t            din,
   input  logic              bubble,
   input  logic              cancel,
   input  logic [AW_MAX-1:0] ra1E,
   input  logic [AW_MAX-1:0] ra2E,
   input  logic              use1E,
   input  logic              use2E,
   input  logic [AW_MAX-1:0] ra1D,
   input  logic [AW_MAX-1:0] ra2D,
   input  logic              use1D,
   input  logic              use2D,
   output entry_t            q,
   output logic              fwd_a,
   output logic              fwd_b,
   output logic              ld_hit,
   output logic              pc_hit
);
   logic fwd_ready;
   logic ld_late;

   always_ff @(posedge clk) begin
      if (reset || bubble) begin
         q <= '0;
      end else begin
         q       <= din;
         q.valid <= din.valid & ~cancel;
      end
   end

   // The result exists at this position once POS has caught up with its latency.
   assign fwd_ready = (POS >= int'(q.lat));
   // A D consumer would sit in E when this producer is at POS+1; too early if lat exceeds that.
   assign ld_late   = (int'(q.lat) > POS + 1);

   assign fwd_a  = q.valid && use1E && (q.wa == ra1E) && fwd_ready;
   assign fwd_b  = q.valid && use2E && (q.wa == ra2E) && fwd_ready;
   assign ld_hit = q.valid && ld_late &&
                   ((use1D && (q.wa == ra1D)) || (use2D && (q.wa == ra2D)));
   assign pc_hit = q.valid && (q.wa == AW_MAX'(PC_ADDR));
endmodule

// File: rtl/hazard_scoreboard.sv
// Hazard/forwarding controller: tracks in-flight writes E..W and derives forward selects,
// load-use stalls, PC-write stalls and branch flushes combinationally from that state.
module hazard_scoreboard
   import hazard_pkg::*;
#(
   parameter int NREG  = 16,
   parameter int AW    = $clog2(NREG),
   parameter int DEPTH = 3,
   parameter int LW    = LW_DEF,
   parameter int FW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [AW-1:0] ra1D,
   input  logic [AW-1:0] ra2D,
   input  logic          use1D,
   input  logic          use2D,
   input  logic [AW-1:0] wa3D,
   input  logic          wevD,
   input  logic [LW-1:0] latD,
   input  logic          BranchTakenE,
   input  logic          cancelE,
   output logic [FW-1:0] ForwardAE,
   output logic [FW-1:0] ForwardBE,
   output logic          StallF,
   output logic          StallD,
   output logic          FlushD,
   output logic          FlushE,
   output logic [31:0]   stall_cnt
);
   logic [AW-1:0]        ra1E, ra2E;
   logic                 use1E, use2E;
   entry_t [DEPTH:0]     chain;
   logic [DEPTH-1:0]     fwd_a, fwd_b, ld_hit, pc_hit;
   logic                 ld_stall, pc_pend;
   logic                 unused_retire;

   // chain[0] is the Decode instruction; chain[p+1] is the state held at position p.
   always_comb begin
      chain[0]       = '0;
      chain[0].valid = wevD;
      chain[0].wa    = AW_MAX'(wa3D);
      chain[0].lat   = (latD == '0) ? LW_MAX'(1) : LW_MAX'(latD);
   end

   for (genvar p = 0; p < DEPTH; p++) begin : g_pos
      hazard_entry #(.POS(p), .PC_ADDR(NREG - 1)) u_entry (
         .clk    (clk),
         .reset  (reset),
         .din    (chain[p]),
         .bubble ((p == 0) ? FlushE : 1'b0),
         .cancel ((p == 1) ? cancelE : 1'b0),
         .ra1E   (AW_MAX'(ra1E)),
         .ra2E   (AW_MAX'(ra2E)),
         .use1E  (use1E),
         .use2E  (use2E),
         .ra1D   (AW_MAX'(ra1D)),
         .ra2D   (AW_MAX'(ra2D)),
         .use1D  (use1D),
         .use2D  (use2D),
         .q      (chain[p+1]),
         .fwd_a  (fwd_a[p]),
         .fwd_b  (fwd_b[p]),
         .ld_hit (ld_hit[p]),
         .pc_hit (pc_hit[p])
      );
   end

   assign unused_retire = ^chain[DEPTH];

   // Scan oldest to youngest so the youngest qualifying producer overrides.
   // Position 0 never qualifies (lat >= 1), and its code equals the register-file code anyway.
   always_comb begin
      ForwardAE = FW'(FWD_RF);
      ForwardBE = FW'(FWD_RF);
      for (int p = DEPTH - 1; p >= 0; p--) begin
         if (fwd_a[p]) ForwardAE = FW'(p);
         if (fwd_b[p]) ForwardBE = FW'(p);
      end
   end

   assign ld_stall = |ld_hit;
   assign pc_pend  = (|pc_hit) || (wevD && (wa3D == AW'(NREG - 1)));

   assign StallD = ld_stall;
   assign StallF = ld_stall | pc_pend;
   assign FlushE = ld_stall | BranchTakenE;
   assign FlushD = pc_pend | BranchTakenE;

   always_ff @(posedge clk) begin
      if (reset || FlushE) begin
         ra1E  <= '0;
         ra2E  <= '0;
         use1E <= 1'b0;
         use2E <= 1'b0;
      end else begin
         ra1E  <= ra1D;
         ra2E  <= ra2D;
         use1E <= use1D;
         use2E <= use2D;
      end
   end

   always_ff @(posedge clk) begin
      if (reset)
         stall_cnt <= '0;
      else if (StallD && (stall_cnt != '1))
         stall_cnt <= stall_cnt + 32'd1;
   end
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench: each cycle pushes the expected hazard outputs, then pops and asserts them mid-cycle.
module tb_hazard_scoreboard;
   localparam int NREG  = 16;
   localparam int AW    = 4;
   localparam int DEPTH = 3;
   localparam int LW    = 2;
   localparam int FW    = 2;

   logic          clk = 1'b0;
   logic          reset;
   logic [AW-1:0] ra1D, ra2D, wa3D;
   logic          use1D, use2D, wevD;
   logic [LW-1:0] latD;
   logic          BranchTakenE, cancelE;
   logic [FW-1:0] ForwardAE, ForwardBE;
   logic          StallF, StallD, FlushD, FlushE;
   logic [31:0]   stall_cnt;

   typedef struct {
      string       tag;
      int          fa;
      int          fb;
      logic        sf, sd, fd, fe;
      logic [31:0] cnt;
   } exp_t;

   exp_t        exp_q[$];
   logic [31:0] exp_cnt = '0;
   int          n_assert = 0;
   int          n_fail = 0;

   hazard_scoreboard #(.NREG(NREG), .AW(AW), .DEPTH(DEPTH), .LW(LW), .FW(FW)) dut (
      .clk(clk), .reset(reset),
      .ra1D(ra1D), .ra2D(ra2D), .use1D(use1D), .use2D(use2D),
      .wa3D(wa3D), .wevD(wevD), .latD(latD),
      .BranchTakenE(BranchTakenE), .cancelE(cancelE),
      .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
      .StallF(StallF), .StallD(StallD), .FlushD(FlushD), .FlushE(FlushE),
      .stall_cnt(stall_cnt)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: bench did not reach its end");
      $fatal(1, "timeout");
   end

   task automatic drive(input logic [AW-1:0] a1, input logic u1, input logic [AW-1:0] a2,
                        input logic u2, input logic [AW-1:0] w, input logic we,
                        input logic [LW-1:0] l, input logic br, input logic cn);
      ra1D = a1; use1D = u1; ra2D = a2; use2D = u2;
      wa3D = w;  wevD = we;  latD = l;
      BranchTakenE = br; cancelE = cn;
   endtask

   task automatic idle();
      drive(0, 0, 0, 0, 0, 0, 2'd1, 0, 0);
   endtask

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Counter model: the count seen this cycle reflects stalls of earlier cycles only.
   task automatic push(input string tag, input int fa, input int fb,
                       input logic sf, input logic sd, input logic fd, input logic fe);
      exp_t e;
      e.tag = tag; e.fa = fa; e.fb = fb;
      e.sf = sf; e.sd = sd; e.fd = fd; e.fe = fe;
      e.cnt = exp_cnt;
      exp_q.push_back(e);
      if (sd && exp_cnt != 32'hFFFF_FFFF) exp_cnt = exp_cnt + 1;
   endtask

   task automatic cmp(input string tag, input string fld, input logic [31:0] obs,
                      input logic [31:0] expv);
      n_assert++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s.%s observed=%0h expected=%0h", tag, fld, obs, expv);
      end
   endtask

   task automatic check();
      exp_t e;
      @(negedge clk);
      if (exp_q.size() == 0) begin
         n_assert++;
         n_fail++;
         $error("FAIL scoreboard underflow observed=0 expected=1");
      end else begin
         e = exp_q.pop_front();
         cmp(e.tag, "ForwardAE", 32'(ForwardAE), 32'(e.fa));
         cmp(e.tag, "ForwardBE", 32'(ForwardBE), 32'(e.fb));
         cmp(e.tag, "StallF",    32'(StallF),    32'(e.sf));
         cmp(e.tag, "StallD",    32'(StallD),    32'(e.sd));
         cmp(e.tag, "FlushD",    32'(FlushD),    32'(e.fd));
         cmp(e.tag, "FlushE",    32'(FlushE),    32'(e.fe));
         cmp(e.tag, "stall_cnt", stall_cnt,      e.cnt);
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset = 1'b1;
      idle();
      tick(2);
      reset = 1'b0;
      push("reset", 0, 0, 0, 0, 0, 0); check();

      // ALU producer immediately followed by a consumer forwards from M
      drive(0, 0, 0, 0, 1, 1, 2'd1, 0, 0);  push("alu_prod", 0, 0, 0, 0, 0, 0); check();
      drive(1, 1, 3, 1, 2, 1, 2'd1, 0, 0);  push("alu_cons", 0, 0, 0, 0, 0, 0); check();
      idle();                               push("alu_fwd",  1, 0, 0, 0, 0, 0); check();
      tick(3);

      // Load then dependent instruction: one stall, then forward both from W
      drive(0, 0, 0, 0, 4, 1, 2'd2, 0, 0);  push("ld_prod",  0, 0, 0, 0, 0, 0); check();
      drive(4, 1, 4, 1, 5, 1, 2'd1, 0, 0);  push("ld_stall", 0, 0, 1, 1, 0, 1); check();
      drive(4, 1, 4, 1, 5, 1, 2'd1, 0, 0);  push("ld_go",    0, 0, 0, 0, 0, 0); check();
      idle();                               push("ld_fwd",   2, 2, 0, 0, 0, 0); check();
      tick(3);

      // Two writers of r6: the younger one supplies the value
      drive(0, 0, 0, 0, 6, 1, 2'd1, 0, 0);  push("yng_w1",   0, 0, 0, 0, 0, 0); check();
      drive(0, 0, 0, 0, 6, 1, 2'd1, 0, 0);  push("yng_w2",   0, 0, 0, 0, 0, 0); check();
      drive(6, 1, 0, 0, 0, 0, 2'd1, 0, 0);  push("yng_cons", 0, 0, 0, 0, 0, 0); check();
      idle();                               push("yng_fwd",  1, 0, 0, 0, 0, 0); check();
      tick(3);

      // Latency 3 with DEPTH 3: two stalls, producer has retired by the time E reads
      drive(0, 0, 0, 0, 7, 1, 2'd3, 0, 0);  push("l3_prod",  0, 0, 0, 0, 0, 0); check();
      drive(0, 0, 7, 1, 0, 0, 2'd1, 0, 0);  push("l3_st1",   0, 0, 1, 1, 0, 1); check();
      drive(0, 0, 7, 1, 0, 0, 2'd1, 0, 0);  push("l3_st2",   0, 0, 1, 1, 0, 1); check();
      drive(0, 0, 7, 1, 0, 0, 2'd1, 0, 0);  push("l3_go",    0, 0, 0, 0, 0, 0); check();
      idle();                               push("l3_rf",    0, 0, 0, 0, 0, 0); check();
      tick(3);

      // PC write: FlushD/StallF from Decode until the entry leaves W
      drive(0, 0, 0, 0, 15, 1, 2'd1, 0, 0); push("pc_d",     0, 0, 1, 0, 1, 0); check();
      idle();                               push("pc_e",     0, 0, 1, 0, 1, 0); check();
      idle();                               push("pc_m",     0, 0, 1, 0, 1, 0); check();
      idle();                               push("pc_w",     0, 0, 1, 0, 1, 0); check();
      idle();                               push("pc_done",  0, 0, 0, 0, 0, 0); check();
      tick(2);

      // Branch taken while a load-use stall is pending
      drive(0, 0, 0, 0, 4, 1, 2'd2, 0, 0);  push("br_ld",    0, 0, 0, 0, 0, 0); check();
      drive(4, 1, 0, 0, 0, 0, 2'd1, 1, 0);  push("br_both",  0, 0, 1, 1, 1, 1); check();
      idle();                               push("br_after", 0, 0, 0, 0, 0, 0); check();
      tick(3);

      // Cancelled E producer must not forward from M
      drive(0, 0, 0, 0, 9, 1, 2'd1, 0, 0);  push("cn_prod",  0, 0, 0, 0, 0, 0); check();
      drive(9, 1, 0, 0, 0, 0, 2'd1, 0, 1);  push("cn_cons",  0, 0, 0, 0, 0, 0); check();
      idle();                               push("cn_nofwd", 0, 0, 0, 0, 0, 0); check();
      tick(3);

      // Reset with three live entries discards them all
      drive(0, 0, 0, 0, 1, 1, 2'd1, 0, 0);  tick(1);
      drive(0, 0, 0, 0, 1, 1, 2'd2, 0, 0);  tick(1);
      drive(0, 0, 0, 0, 1, 1, 2'd1, 0, 0);  tick(1);
      idle();
      reset = 1'b1;
      tick(1);
      reset = 1'b0;
      exp_cnt = '0;
      push("rst_mid",  0, 0, 0, 0, 0, 0); check();
      drive(1, 1, 0, 0, 0, 0, 2'd1, 0, 0);  push("rst_cons", 0, 0, 0, 0, 0, 0); check();
      idle();                               push("rst_rf",   0, 0, 0, 0, 0, 0); check();

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
